// File: rtl/mmu_port_arbiter_pkg.sv
// Shared types for the MMU port arbiter: MMU interface codes, arbiter
// state encoding and grant-select codes.
package mmu_port_arbiter_pkg;

  typedef enum logic [2:0] {
    EXC_NONE        = 3'd0,
    EXC_TLB_MISS    = 3'd1,
    EXC_TLB_INVALID = 3'd2,
    EXC_TLB_MOD     = 3'd3,
    EXC_ADDR_ERR    = 3'd4
  } mmu_exception_t;

  typedef enum logic [1:0] {
    ACC_FETCH = 2'd0,
    ACC_LOAD  = 2'd1,
    ACC_STORE = 2'd2
  } mem_access_t;

  typedef enum logic [2:0] {
    CMD_NONE              = 3'd0,
    CMD_READ_REG          = 3'd1,
    CMD_WRITE_REG         = 3'd2,
    CMD_READ_TLB          = 3'd3,
    CMD_WRITE_TLB_INDEXED = 3'd4,
    CMD_WRITE_TLB_RANDOM  = 3'd5,
    CMD_PROBE_TLB         = 3'd6
  } mmu_cmd_t;

  typedef enum logic [2:0] {
    REG_INDEX    = 3'd0,
    REG_RANDOM   = 3'd1,
    REG_ENTRYLO0 = 3'd2,
    REG_ENTRYLO1 = 3'd3,
    REG_CONTEXT  = 3'd4,
    REG_PAGEMASK = 3'd5,
    REG_WIRED    = 3'd6,
    REG_ENTRYHI  = 3'd7
  } mmu_reg_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2,
    S_RAND  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_IF = 2'd0,
    GNT_D  = 2'd1,
    GNT_CP = 2'd2
  } gnt_t;

endpackage

// File: rtl/mmu_port_arbiter_random_ctr.sv
// Shadow copy of the MMU Random and Wired registers. Produces the value
// Random takes after the next random TLB write: it counts down and wraps
// from Wired back to the top entry.
module mmu_random_ctr #(
  parameter int ENTRY_ADDR_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        res,
  input  logic                        load_wired,
  input  logic                        load_rand,
  input  logic                        step,
  input  logic [ENTRY_ADDR_WIDTH-1:0] data,
  output logic [ENTRY_ADDR_WIDTH-1:0] rand_next
);

  localparam logic [ENTRY_ADDR_WIDTH-1:0] RAND_TOP = '1;

  logic [ENTRY_ADDR_WIDTH-1:0] rand_q;
  logic [ENTRY_ADDR_WIDTH-1:0] wired_q;

  // Next Random: wrap to the top entry once the wired boundary is reached.
  always_comb begin
    rand_next = (rand_q == wired_q) ? RAND_TOP : rand_q - 1'b1;
  end

  // Shadow register updates; writing Wired also restarts Random at the top.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rand_q  <= RAND_TOP;
      wired_q <= '0;
    end else if (load_wired) begin
      wired_q <= data;
      rand_q  <= RAND_TOP;
    end else if (load_rand) begin
      rand_q <= data;
    end else if (step) begin
      rand_q <= rand_next;
    end
  end

endmodule

// File: rtl/mmu_port_arbiter.sv
// Shares the single MMU lookup/command port between fetch, data and CP0.
// Each granted request is issued for one cycle, the registered MMU result
// is captured and returned with a one-cycle ack. Random TLB writes are
// followed by a write of the next Random value back into the MMU.
module mmu_port_arbiter
  import mmu_port_arbiter_pkg::*;
#(
  parameter int ENTRY_ADDR_WIDTH = 3,
  parameter int STARVE_LIMIT     = 4
) (
  input  logic           clk,
  input  logic           res,
  input  logic           if_req,
  input  logic [31:0]    if_vaddr,
  output logic           if_ack,
  output logic [31:0]    if_paddr,
  output mmu_exception_t if_exc,
  input  logic           d_req,
  input  logic [31:0]    d_vaddr,
  input  mem_access_t    d_access,
  output logic           d_ack,
  output logic [31:0]    d_paddr,
  output mmu_exception_t d_exc,
  input  logic           cp_req,
  input  mmu_cmd_t       cp_cmd,
  input  mmu_reg_t       cp_reg,
  input  logic [31:0]    cp_wdata,
  output logic           cp_ack,
  output logic [31:0]    cp_rdata,
  output logic           mmu_addrValid,
  output logic [31:0]    mmu_vAddr,
  output mem_access_t    mmu_accessType,
  output mmu_cmd_t       mmu_cmd,
  output mmu_reg_t       mmu_reg,
  output logic [31:0]    mmu_dataIn,
  input  logic [31:0]    mmu_pAddr,
  input  mmu_exception_t mmu_exception,
  input  logic [31:0]    mmu_dataOut
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  arb_state_t state_reg, state_next;
  gnt_t       gnt_reg;
  mmu_cmd_t   cmd_reg;
  logic [SC_W-1:0] starve_cnt;

  logic req_if, req_d, req_cp, grant_valid;
  gnt_t grant;
  logic load_wired, load_rand, rand_step;
  logic [ENTRY_ADDR_WIDTH-1:0] rand_next;

  // Arbitration: a requester being acked this cycle is still holding req, so mask it.
  always_comb begin
    req_if      = if_req & ~if_ack;
    req_d       = d_req & ~d_ack;
    req_cp      = cp_req & ~cp_ack;
    grant       = GNT_IF;
    grant_valid = 1'b0;
    if (req_cp) begin
      grant       = GNT_CP;
      grant_valid = 1'b1;
    end else if (req_d && !(req_if && starve_cnt == STARVE_MAX)) begin
      grant       = GNT_D;
      grant_valid = 1'b1;
    end else if (req_if) begin
      grant       = GNT_IF;
      grant_valid = 1'b1;
    end
  end

  // Next-state sequencing: IDLE -> ISSUE -> RESP -> (RAND) -> IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (grant_valid) state_next = S_ISSUE;
      S_ISSUE: state_next = S_RESP;
      S_RESP:  state_next = (gnt_reg == GNT_CP && cmd_reg == CMD_WRITE_TLB_RANDOM) ? S_RAND : S_IDLE;
      S_RAND:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge res) begin
    if (!res) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // During ISSUE the registered mmu_* outputs still hold the latched CP0 operands.
  assign load_wired = (state_reg == S_ISSUE) && (mmu_cmd == CMD_WRITE_REG) && (mmu_reg == REG_WIRED);
  assign load_rand  = (state_reg == S_ISSUE) && (mmu_cmd == CMD_WRITE_REG) && (mmu_reg == REG_RANDOM);
  assign rand_step  = (state_reg == S_RAND);

  mmu_random_ctr #(
    .ENTRY_ADDR_WIDTH(ENTRY_ADDR_WIDTH)
  ) u_random_ctr (
    .clk       (clk),
    .res       (res),
    .load_wired(load_wired),
    .load_rand (load_rand),
    .step      (rand_step),
    .data      (mmu_dataIn[ENTRY_ADDR_WIDTH-1:0]),
    .rand_next (rand_next)
  );

  // Datapath: latch the winner, drive the MMU for one cycle, capture and ack.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      gnt_reg        <= GNT_IF;
      cmd_reg        <= CMD_NONE;
      starve_cnt     <= '0;
      if_ack         <= 1'b0;
      if_paddr       <= '0;
      if_exc         <= EXC_NONE;
      d_ack          <= 1'b0;
      d_paddr        <= '0;
      d_exc          <= EXC_NONE;
      cp_ack         <= 1'b0;
      cp_rdata       <= '0;
      mmu_addrValid  <= 1'b0;
      mmu_vAddr      <= '0;
      mmu_accessType <= ACC_FETCH;
      mmu_cmd        <= CMD_NONE;
      mmu_reg        <= REG_INDEX;
      mmu_dataIn     <= '0;
    end else begin
      if_ack        <= 1'b0;
      d_ack         <= 1'b0;
      cp_ack        <= 1'b0;
      mmu_addrValid <= 1'b0;
      mmu_cmd       <= CMD_NONE;
      case (state_reg)
        S_IDLE: begin
          if (grant_valid) begin
            gnt_reg <= grant;
            cmd_reg <= (grant == GNT_CP) ? cp_cmd : CMD_NONE;
            if (grant == GNT_CP) begin
              mmu_cmd    <= cp_cmd;
              mmu_reg    <= cp_reg;
              mmu_dataIn <= cp_wdata;
            end else begin
              mmu_addrValid  <= 1'b1;
              mmu_vAddr      <= (grant == GNT_D) ? d_vaddr : if_vaddr;
              mmu_accessType <= (grant == GNT_D) ? d_access : ACC_FETCH;
            end
            if (grant == GNT_IF)
              starve_cnt <= '0;
            else if (grant == GNT_D && req_if && starve_cnt != STARVE_MAX)
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        S_RESP: begin
          case (gnt_reg)
            GNT_IF: begin
              if_paddr <= mmu_pAddr;
              if_exc   <= mmu_exception;
              if_ack   <= 1'b1;
            end
            GNT_D: begin
              d_paddr <= mmu_pAddr;
              d_exc   <= mmu_exception;
              d_ack   <= 1'b1;
            end
            default: begin
              if (cmd_reg == CMD_READ_REG) cp_rdata <= mmu_dataOut;
              if (cmd_reg == CMD_WRITE_TLB_RANDOM) begin
                mmu_cmd    <= CMD_WRITE_REG;
                mmu_reg    <= REG_RANDOM;
                mmu_dataIn <= {{(32 - ENTRY_ADDR_WIDTH){1'b0}}, rand_next};
              end else begin
                cp_ack <= 1'b1;
              end
            end
          endcase
        end
        S_RAND:  cp_ack <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mmu_port_arbiter.md
Name: mmu_port_arbiter

Overview:
- Sequences and shares the single MMU lookup/command port between three requesters: instruction fetch (if_*), data access (d_*) and the CP0 TLB/register command channel (cp_*).
- Registers each request, issues it to the MMU for exactly one cycle, captures the registered MMU result and returns it with a one-cycle ack.
- Owns Random-register sequencing: after every TLB random write it writes the next Random value back into the MMU.

Parameters:
ENTRY_ADDR_WIDTH, 3, log2 of TLB entry count; ENTRY_COUNT = 1 << ENTRY_ADDR_WIDTH.
STARVE_LIMIT, 4, consecutive lost arbitrations after which fetch wins once over data.

Ports:
clk  in  1  clock, rising edge.
res  in  1  reset, asynchronous, active-low.
if_req  in  1  fetch translation request; held with if_vaddr until if_ack.
if_vaddr  in  32  fetch virtual address.
if_ack  out  1  one-cycle pulse; if_paddr and if_exc valid this cycle.
if_paddr  out  32  translated address.
if_exc  out  `MMU_EXCEPTION_T  lookup exception.
d_req  in  1  data translation request; held with d_vaddr/d_access until d_ack.
d_vaddr  in  32  data virtual address.
d_access  in  `MEM_ACCESS_T  access type forwarded to the MMU.
d_ack  out  1  one-cycle pulse.
d_paddr  out  32  translated address.
d_exc  out  `MMU_EXCEPTION_T  lookup exception.
cp_req  in  1  CP0 command request; held with cp_* until cp_ack.
cp_cmd  in  `MMU_CMD_T  command code.
cp_reg  in  `MMU_REG_T  register selector for READ_REG and WRITE_REG.
cp_wdata  in  32  write data.
cp_ack  out  1  one-cycle pulse.
cp_rdata  out  32  MMU register read data, valid with cp_ack for READ_REG.
mmu_addrValid  out  1  lookup strobe.
mmu_vAddr  out  32  to MMU vAddrIn.
mmu_accessType  out  `MEM_ACCESS_T  to MMU.
mmu_cmd  out  `MMU_CMD_T  to MMU.
mmu_reg  out  `MMU_REG_T  to MMU.
mmu_dataIn  out  32  to MMU.
mmu_pAddr  in  32  from MMU pAddrOut.
mmu_exception  in  `MMU_EXCEPTION_T  from MMU.
mmu_dataOut  in  32  from MMU.

Behaviour:
- Reset (res=0, asynchronous):
  - state = S_IDLE; all acks 0; paddr, rdata and exc outputs 0.
  - mmu_addrValid = 0; mmu_cmd = `MMU_CMD_NONE.
  - rand_q = ENTRY_COUNT-1; wired_q = 0; starve_cnt = 0.
  - A request in flight is dropped; no ack is ever issued for it.
- MMU output drive:
  - All mmu_* outputs are registered.
  - Outside S_ISSUE and S_RAND: mmu_addrValid = 0, mmu_cmd = NONE.
- States:
  - S_IDLE: arbitrate; latch the winner's operands into holding registers; go to S_ISSUE.
  - S_ISSUE: drive the MMU for one cycle.
    - Lookup: mmu_addrValid = 1, mmu_vAddr = held address, mmu_cmd = NONE.
    - Command: mmu_addrValid = 0, mmu_cmd/reg/dataIn = held values.
  - S_RESP: MMU results are valid.
    - At the edge leaving S_RESP, capture mmu_pAddr/mmu_exception (lookup) or mmu_dataOut (READ_REG) into the winner's outputs and set its ack for the next cycle.
    - Next state is S_IDLE, except a WRITE_TLB_RANDOM command, which goes to S_RAND and defers cp_ack.
  - S_RAND: issue WRITE_REG to `MMU_REG_RANDOM with rand_next; update rand_q; go to S_IDLE; cp_ack pulses the next cycle.
- Latency:
  - Lookups and plain commands: ack in the 4th cycle after req is sampled in S_IDLE (IDLE, ISSUE, RESP, ack).
  - WRITE_TLB_RANDOM: one extra cycle.
- Arbitration, sampled in S_IDLE only:
  - Any requester whose ack is high this cycle is masked.
  - Priority is cp > d > if.
  - Exception: if starve_cnt == STARVE_LIMIT and if_req is set, fetch beats data (cp still wins).
  - starve_cnt increments when fetch is requesting and loses to data, saturating at STARVE_LIMIT. It clears when fetch is granted.
- Random sequencing:
  - rand_next = (rand_q == wired_q) ? ENTRY_COUNT-1 : rand_q-1, all arithmetic ENTRY_ADDR_WIDTH bits wide.
  - held mmu_dataIn for WRITE_TLB_RANDOM is unaffected (the MMU uses its own Random).
- Shadow registers:
  - cp WRITE_REG to WIRED sets wired_q = cp_wdata[ENTRY_ADDR_WIDTH-1:0] and rand_q = ENTRY_COUNT-1.
  - cp WRITE_REG to RANDOM sets rand_q from cp_wdata.
  - Both updates happen in S_ISSUE.
- Requester protocol:
  - A requester deasserts req, or presents a new request, in the cycle after ack.
  - Changing the operands of a held request before ack is illegal. The arbiter latches the operands in S_IDLE and ignores later changes.
- Simultaneous requests: the losers remain pending; they are not reordered or merged.

Decomposition:
- mmu.vh additions:
  - `MMU_CMD_NONE, if it is not already present.
  - Arbiter state encodings S_IDLE, S_ISSUE, S_RESP, S_RAND (2-bit).
  - Grant-select codes GNT_IF, GNT_D, GNT_CP.
- One natural sub-module, mmu_random_ctr, holding rand_q and wired_q:
  - Inputs: load_wired, load_rand, step, data.
  - Output: rand_next.

Test Plan:
- Reset, then if_req with if_vaddr=32'h0040_1000 and a TLB mapping to 32'h0001_2000 -> mmu_addrValid high for exactly 1 cycle; if_ack after 3 cycles; if_paddr=32'h0001_2000, if_exc=NONE.
- if_req and d_req asserted together, 6 back-to-back times -> d wins 4 times, then if is granted on the 5th; starve_cnt returns to 0.
- cp_req, d_req and if_req together -> order of acks is cp, d, if; no two acks in the same cycle.
- cp WRITE_REG WIRED=2, then WRITE_TLB_RANDOM ×7 -> RANDOM writes 6,5,4,3,2,7,6; each cp_ack arrives 1 cycle later than a plain command's.
- cp READ_REG ENTRYHI after a cp write of 32'h1234_6001 -> cp_rdata=32'h1234_6001 with cp_ack.
- res pulled low during S_RESP of a d request -> d_ack never pulses; mmu_cmd=NONE and mmu_addrValid=0 immediately; normal operation after release.
